// File: rtl/switch_arb_port.sv
// -----------------------------------------------------------------------------
// switch_arb_port
//   NCH input channels, each with a 2**DEPTH-entry FIFO, arbitrated into one
//   registered output stage. Arbitration is round-robin (PRIO = 0) or fixed
//   priority with the lowest index winning (PRIO = 1). The output word carries
//   the source channel index above the data.
//
// Ports
//   clk_i      : clock, all state updates on the rising edge
//   rst_i      : asynchronous, active-low reset
//   validtx_i  : per-channel input word valid
//   dat_i      : per-channel input data, channel k at [k*DW +: DW]
//   acktx_o    : per-channel ready, high while that FIFO is not full
//   validrx_o  : output word valid
//   dat_o      : output word {source index, data}
//   ackrx_i    : downstream accepts the output word
// -----------------------------------------------------------------------------
module switch_arb_port #(
    parameter int DW    = 4,
    parameter int DEPTH = 2,
    parameter int NCH   = 3,
    parameter int SW    = 2,
    parameter int PRIO  = 0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [NCH-1:0]    validtx_i,
    input  logic [NCH*DW-1:0] dat_i,
    output logic [NCH-1:0]    acktx_o,
    output logic              validrx_o,
    output logic [DW+SW-1:0]  dat_o,
    input  logic              ackrx_i
);

    localparam int NENT = 2 ** DEPTH;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    logic [DW-1:0]    mem_q    [NCH][NENT];
    logic [DEPTH-1:0] wr_ptr_q [NCH];
    logic [DEPTH-1:0] wr_ptr_d [NCH];
    logic [DEPTH-1:0] rd_ptr_q [NCH];
    logic [DEPTH-1:0] rd_ptr_d [NCH];
    logic [DEPTH:0]   cnt_q    [NCH];
    logic [DEPTH:0]   cnt_d    [NCH];

    logic [NCH-1:0]   nonempty_s;
    logic [NCH-1:0]   full_s;
    logic [NCH-1:0]   wr_en_s;
    logic [NCH-1:0]   pop_s;

    logic [SW-1:0]    grant_s;
    logic             grant_vld_s;
    logic             load_s;
    logic [DW-1:0]    head_s;

    logic [SW-1:0]    last_grant_q;
    logic [SW-1:0]    last_grant_d;
    logic [DW+SW-1:0] dat_q;
    logic [DW+SW-1:0] dat_d;
    state_t           state_q;
    state_t           state_d;

    // Per-channel FIFO status; full is the occupancy MSB (count == 2**DEPTH).
    // A full FIFO refuses writes even when it is popped in the same cycle.
    always_comb begin
        nonempty_s = {NCH{1'b0}};
        full_s     = {NCH{1'b0}};
        wr_en_s    = {NCH{1'b0}};
        for (int k = 0; k < NCH; k++) begin
            nonempty_s[k] = (cnt_q[k] != {(DEPTH+1){1'b0}});
            full_s[k]     = cnt_q[k][DEPTH];
            wr_en_s[k]    = validtx_i[k] & ~cnt_q[k][DEPTH];
        end
    end

    // Arbiter: scan NCH candidates, first non-empty one wins. Round-robin
    // starts at last_grant+1 with wrap; fixed priority starts at index 0.
    always_comb begin
        grant_s     = {SW{1'b0}};
        grant_vld_s = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            int  rot;
            int  idx;
            logic hit;
            rot = int'(last_grant_q) + 1 + i;
            rot = (rot >= NCH) ? (rot - NCH) : rot;
            idx = (PRIO == 1) ? i : rot;
            hit = ~grant_vld_s & nonempty_s[idx];
            grant_s     = hit ? SW'(idx) : grant_s;
            grant_vld_s = grant_vld_s | hit;
        end
    end

    // Load decision, pop strobes and the head word of the granted FIFO.
    always_comb begin
        load_s = grant_vld_s & ((state_q == ST_EMPTY) | ackrx_i);
        pop_s  = {NCH{1'b0}};
        for (int k = 0; k < NCH; k++) begin
            pop_s[k] = load_s & (grant_s == SW'(k));
        end
        head_s = mem_q[grant_s][rd_ptr_q[grant_s]];
    end

    // FIFO pointer and occupancy next-state.
    always_comb begin
        for (int k = 0; k < NCH; k++) begin
            wr_ptr_d[k] = wr_en_s[k] ? (wr_ptr_q[k] + DEPTH'(1)) : wr_ptr_q[k];
            rd_ptr_d[k] = pop_s[k]   ? (rd_ptr_q[k] + DEPTH'(1)) : rd_ptr_q[k];
            cnt_d[k]    = cnt_q[k] + (DEPTH+1)'(wr_en_s[k]) - (DEPTH+1)'(pop_s[k]);
        end
    end

    // Output word and round-robin pointer next-state.
    always_comb begin
        dat_d        = load_s ? {grant_s, head_s} : dat_q;
        last_grant_d = (load_s && (PRIO == 0)) ? grant_s : last_grant_q;
    end

    // FIFO storage; no reset needed because pointers and counts define validity.
    always_ff @(posedge clk_i) begin
        for (int k = 0; k < NCH; k++) begin
            if (wr_en_s[k]) begin
                mem_q[k][wr_ptr_q[k]] <= dat_i[k*DW +: DW];
            end
        end
    end

    // Datapath and FIFO control registers.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            dat_q        <= {(DW+SW){1'b0}};
            last_grant_q <= SW'(NCH - 1);
            for (int k = 0; k < NCH; k++) begin
                wr_ptr_q[k] <= {DEPTH{1'b0}};
                rd_ptr_q[k] <= {DEPTH{1'b0}};
                cnt_q[k]    <= {(DEPTH+1){1'b0}};
            end
        end else begin
            dat_q        <= dat_d;
            last_grant_q <= last_grant_d;
            for (int k = 0; k < NCH; k++) begin
                wr_ptr_q[k] <= wr_ptr_d[k];
                rd_ptr_q[k] <= rd_ptr_d[k];
                cnt_q[k]    <= cnt_d[k];
            end
        end
    end

    // Output stage state register.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Output stage next state: stay FULL while held or refilled on transfer.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: state_d = load_s ? ST_FULL : ST_EMPTY;
            ST_FULL: begin
                if (ackrx_i) begin
                    state_d = load_s ? ST_FULL : ST_EMPTY;
                end else begin
                    state_d = ST_FULL;
                end
            end
            default:  state_d = ST_EMPTY;
        endcase
    end

    // Outputs, all taken from registered state.
    always_comb begin
        validrx_o = (state_q == ST_FULL);
        dat_o     = dat_q;
        acktx_o   = ~full_s;
    end

endmodule

// File: tb/tb_switch_arb_port.sv
// -----------------------------------------------------------------------------
// tb_switch_arb_port
//   Directed bench for switch_arb_port. Two instances share all inputs:
//   dut0 uses round-robin arbitration, dut1 fixed priority. Each vector is
//   driven on a falling edge and the outputs are compared 1 time unit after
//   the following rising edge.
// -----------------------------------------------------------------------------
module tb_switch_arb_port;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic [2:0]  validtx_i = 3'b000;
    logic [11:0] dat_i = 12'h000;
    logic        ackrx_i = 1'b0;

    logic [2:0]  acktx0, acktx1;
    logic        validrx0, validrx1;
    logic [5:0]  dat0, dat1;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [2:0]  validtx;
        logic [11:0] dat;
        logic        ackrx;
        logic        exp_v;
        logic [5:0]  exp_d;
        logic [2:0]  exp_ack;
    } vec_t;

    vec_t tbl[$];

    switch_arb_port #(.DW(4), .DEPTH(2), .NCH(3), .SW(2), .PRIO(0)) dut0 (
        .clk_i(clk_i), .rst_i(rst_i), .validtx_i(validtx_i), .dat_i(dat_i),
        .acktx_o(acktx0), .validrx_o(validrx0), .dat_o(dat0), .ackrx_i(ackrx_i)
    );

    switch_arb_port #(.DW(4), .DEPTH(2), .NCH(3), .SW(2), .PRIO(1)) dut1 (
        .clk_i(clk_i), .rst_i(rst_i), .validtx_i(validtx_i), .dat_i(dat_i),
        .acktx_o(acktx1), .validrx_o(validrx1), .dat_o(dat1), .ackrx_i(ackrx_i)
    );

    always #5 clk_i = ~clk_i;

    function automatic vec_t mk(input logic [2:0] vt, input logic [11:0] d, input logic ack,
                                input logic ev, input logic [5:0] ed, input logic [2:0] ea);
        vec_t v;
        v.validtx = vt; v.dat = d; v.ackrx = ack;
        v.exp_v = ev; v.exp_d = ed; v.exp_ack = ea;
        return v;
    endfunction

    task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Called at a falling edge; drives, waits for the rising edge, compares,
    // and returns at the next falling edge.
    task automatic run_vec(input vec_t v, input bit sel, input string name);
        logic       vo;
        logic [5:0] dout;
        logic [2:0] ako;
        validtx_i = v.validtx;
        dat_i     = v.dat;
        ackrx_i   = v.ackrx;
        @(posedge clk_i);
        #1;
        vo   = sel ? validrx1 : validrx0;
        dout = sel ? dat1 : dat0;
        ako  = sel ? acktx1 : acktx0;
        chk({name, ".validrx"}, {11'd0, vo}, {11'd0, v.exp_v});
        chk({name, ".acktx"}, {9'd0, ako}, {9'd0, v.exp_ack});
        if (v.exp_v) begin
            chk({name, ".dat"}, {6'd0, dout}, {6'd0, v.exp_d});
        end
        @(negedge clk_i);
    endtask

    task automatic do_reset();
        rst_i     = 1'b0;
        validtx_i = 3'b000;
        dat_i     = 12'h000;
        ackrx_i   = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b1;
    endtask

    initial begin
        // Single word on ch1
        tbl.push_back(mk(3'b010, 12'h0A0, 1'b1, 1'b0, 6'h00, 3'b111));
        tbl.push_back(mk(3'b000, 12'h000, 1'b1, 1'b1, 6'h1A, 3'b111));
        tbl.push_back(mk(3'b000, 12'h000, 1'b1, 1'b0, 6'h00, 3'b111));
        // Backpressure: ch0 offers words 1..6, downstream stalled
        tbl.push_back(mk(3'b001, 12'h001, 1'b0, 1'b0, 6'h00, 3'b111));
        tbl.push_back(mk(3'b001, 12'h002, 1'b0, 1'b1, 6'h01, 3'b111));
        tbl.push_back(mk(3'b001, 12'h003, 1'b0, 1'b1, 6'h01, 3'b111));
        tbl.push_back(mk(3'b001, 12'h004, 1'b0, 1'b1, 6'h01, 3'b111));
        tbl.push_back(mk(3'b001, 12'h005, 1'b0, 1'b1, 6'h01, 3'b110));
        tbl.push_back(mk(3'b001, 12'h006, 1'b0, 1'b1, 6'h01, 3'b110));
        tbl.push_back(mk(3'b000, 12'h000, 1'b1, 1'b1, 6'h02, 3'b111));
        tbl.push_back(mk(3'b000, 12'h000, 1'b1, 1'b1, 6'h03, 3'b111));
        tbl.push_back(mk(3'b000, 12'h000, 1'b1, 1'b1, 6'h04, 3'b111));
        tbl.push_back(mk(3'b000, 12'h000, 1'b1, 1'b1, 6'h05, 3'b111));
        tbl.push_back(mk(3'b000, 12'h000, 1'b1, 1'b0, 6'h00, 3'b111));
        // Full FIFO popped while ch0 keeps offering 0xC
        tbl.push_back(mk(3'b001, 12'h007, 1'b0, 1'b0, 6'h00, 3'b111));
        tbl.push_back(mk(3'b001, 12'h008, 1'b0, 1'b1, 6'h07, 3'b111));
        tbl.push_back(mk(3'b001, 12'h009, 1'b0, 1'b1, 6'h07, 3'b111));
        tbl.push_back(mk(3'b001, 12'h00A, 1'b0, 1'b1, 6'h07, 3'b111));
        tbl.push_back(mk(3'b001, 12'h00B, 1'b0, 1'b1, 6'h07, 3'b110));
        tbl.push_back(mk(3'b001, 12'h00C, 1'b1, 1'b1, 6'h08, 3'b111));
        tbl.push_back(mk(3'b001, 12'h00C, 1'b1, 1'b1, 6'h09, 3'b111));
        tbl.push_back(mk(3'b000, 12'h000, 1'b1, 1'b1, 6'h0A, 3'b111));
        tbl.push_back(mk(3'b000, 12'h000, 1'b1, 1'b1, 6'h0B, 3'b111));
        tbl.push_back(mk(3'b000, 12'h000, 1'b1, 1'b1, 6'h0C, 3'b111));
        tbl.push_back(mk(3'b000, 12'h000, 1'b1, 1'b0, 6'h00, 3'b111));

        // Reset state
        @(negedge clk_i);
        @(negedge clk_i);
        chk("rst.validrx0", {11'd0, validrx0}, 12'd0);
        chk("rst.dat0", {6'd0, dat0}, 12'd0);
        chk("rst.acktx0", {9'd0, acktx0}, 12'h007);
        chk("rst.validrx1", {11'd0, validrx1}, 12'd0);
        chk("rst.acktx1", {9'd0, acktx1}, 12'h007);
        rst_i = 1'b1;

        foreach (tbl[i]) begin
            run_vec(tbl[i], 1'b0, $sformatf("vec%0d", i));
        end

        // Round-robin: two words per channel, then drain at full rate
        do_reset();
        run_vec(mk(3'b111, 12'h531, 1'b0, 1'b0, 6'h00, 3'b111), 1'b0, "rr0");
        run_vec(mk(3'b111, 12'h642, 1'b0, 1'b1, 6'h01, 3'b111), 1'b0, "rr1");
        run_vec(mk(3'b000, 12'h000, 1'b1, 1'b1, 6'h13, 3'b111), 1'b0, "rr2");
        run_vec(mk(3'b000, 12'h000, 1'b1, 1'b1, 6'h25, 3'b111), 1'b0, "rr3");
        run_vec(mk(3'b000, 12'h000, 1'b1, 1'b1, 6'h02, 3'b111), 1'b0, "rr4");
        run_vec(mk(3'b000, 12'h000, 1'b1, 1'b1, 6'h14, 3'b111), 1'b0, "rr5");
        run_vec(mk(3'b000, 12'h000, 1'b1, 1'b1, 6'h26, 3'b111), 1'b0, "rr6");
        run_vec(mk(3'b000, 12'h000, 1'b1, 1'b0, 6'h00, 3'b111), 1'b0, "rr7");

        // Fixed priority on dut1: ch0 and ch2 two words each
        do_reset();
        run_vec(mk(3'b101, 12'h501, 1'b0, 1'b0, 6'h00, 3'b111), 1'b1, "fp0");
        run_vec(mk(3'b101, 12'h602, 1'b0, 1'b1, 6'h01, 3'b111), 1'b1, "fp1");
        run_vec(mk(3'b000, 12'h000, 1'b1, 1'b1, 6'h02, 3'b111), 1'b1, "fp2");
        run_vec(mk(3'b000, 12'h000, 1'b1, 1'b1, 6'h25, 3'b111), 1'b1, "fp3");
        run_vec(mk(3'b000, 12'h000, 1'b1, 1'b1, 6'h26, 3'b111), 1'b1, "fp4");
        run_vec(mk(3'b000, 12'h000, 1'b1, 1'b0, 6'h00, 3'b111), 1'b1, "fp5");

        // Reset mid-operation with three words buffered on ch1
        do_reset();
        run_vec(mk(3'b010, 12'h010, 1'b0, 1'b0, 6'h00, 3'b111), 1'b0, "mr0");
        run_vec(mk(3'b010, 12'h020, 1'b0, 1'b1, 6'h11, 3'b111), 1'b0, "mr1");
        run_vec(mk(3'b010, 12'h030, 1'b0, 1'b1, 6'h11, 3'b111), 1'b0, "mr2");
        rst_i     = 1'b0;
        validtx_i = 3'b000;
        dat_i     = 12'h000;
        #1;
        chk("mr.async_validrx", {11'd0, validrx0}, 12'd0);
        chk("mr.async_acktx", {9'd0, acktx0}, 12'h007);
        chk("mr.async_dat", {6'd0, dat0}, 12'd0);
        @(negedge clk_i);
        rst_i = 1'b1;
        run_vec(mk(3'b100, 12'h700, 1'b1, 1'b0, 6'h00, 3'b111), 1'b0, "mr3");
        run_vec(mk(3'b000, 12'h000, 1'b1, 1'b1, 6'h27, 3'b111), 1'b0, "mr4");
        run_vec(mk(3'b000, 12'h000, 1'b1, 1'b0, 6'h00, 3'b111), 1'b0, "mr5");
        run_vec(mk(3'b000, 12'h000, 1'b1, 1'b0, 6'h00, 3'b111), 1'b0, "mr6");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/switch_arb_port.md
SWITCH_ARB_PORT -- requirements
Module: switch_arb_port

Interface
REQ-001 SHALL have parameter DW, default 4, data width per channel in bits.
REQ-002 SHALL have parameter DEPTH, default 2, log2 of per-channel FIFO entries (default 4 entries).
REQ-003 SHALL have parameter NCH, default 3, number of input channels, legal range 2..4.
REQ-004 SHALL have parameter SW, default 2, source-index width; NCH <= 2**SW.
REQ-005 SHALL have parameter PRIO, default 0; 0 = round-robin arbitration, 1 = fixed priority with the lowest index winning.
REQ-006 SHALL have ports:
 clk_i  in  1  single clock, all state on rising edge
 rst_i  in  1  reset, asynchronous assert, active-low
 validtx_i  in  NCH  per-channel word valid
 dat_i  in  NCH*DW  per-channel data, channel k at [k*DW +: DW]
 acktx_o  out  NCH  per-channel ready (FIFO not full)
 validrx_o  out  1  output word valid
 dat_o  out  DW+SW  {source index, data}
 ackrx_i  in  1  downstream accepts output word

Function
REQ-007 SHALL complete an input transfer on channel k at a rising edge where validtx_i[k] and acktx_o[k] are both 1, writing dat_i[k] into FIFO k.
REQ-008 SHALL drive acktx_o[k] = 1 exactly when FIFO k holds fewer than 2**DEPTH entries, from registered state only.
REQ-009 SHALL NOT accept a write into a full FIFO, even if that FIFO is read in the same cycle; acktx_o[k] rises one cycle after the read.
REQ-010 SHALL complete an output transfer at a rising edge where validrx_o and ackrx_i are both 1.
REQ-011 SHALL hold an output stage with states EMPTY (validrx_o = 0) and FULL (validrx_o = 1).
REQ-012 SHALL load the output stage when it is EMPTY, or FULL and transferring in that cycle, and at least one FIFO is non-empty.
 - Load: pop the granted FIFO head; dat_o = {grant index, data}; state becomes FULL.
REQ-013 SHALL move from FULL to EMPTY when the output word transfers and no FIFO is non-empty.
REQ-014 SHALL hold dat_o and validrx_o stable while validrx_o = 1 and ackrx_i = 0.
REQ-015 SHALL sustain one output word per cycle while ackrx_i = 1 and data is pending.
REQ-016 SHALL have a latency of 1 cycle: a word written at edge t into an empty block appears with validrx_o = 1 after edge t+1, with no combinational bypass.
REQ-017 SHALL, with PRIO = 0, grant the first non-empty channel searching upward (with wrap) from last_grant+1, then set last_grant to the granted index.
REQ-018 SHALL, with PRIO = 1, grant the lowest-index non-empty channel and SHALL NOT use last_grant.
REQ-019 SHALL wrap FIFO read/write pointers modulo 2**DEPTH and keep an occupancy counter of DEPTH+1 bits.
REQ-020 SHALL preserve per-channel word order; cross-channel order is set only by arbitration.
REQ-021 SHALL ignore dat_i[k] whenever validtx_i[k] = 0.

Reset
REQ-022 SHALL, while rst_i = 0, asynchronously force:
 - all FIFOs empty and all pointers 0
 - output stage EMPTY, validrx_o = 0, dat_o = 0
 - last_grant = NCH-1, so channel 0 is searched first
 - acktx_o = all ones
REQ-023 SHALL discard all buffered and in-flight words on reset mid-operation and SHALL accept new transfers from the first rising edge after rst_i returns to 1.

Verification
REQ-024 Single word: ch1 writes 0xA with ackrx_i = 1 -> after 1 edge validrx_o = 1, dat_o = {2'd1, 4'hA}; validrx_o = 0 on the next edge.
REQ-025 Round-robin: PRIO = 0, all 3 FIFOs preloaded with 2 words each, ackrx_i = 1 -> source order 0,1,2,0,1,2 on consecutive cycles.
REQ-026 Fixed priority: PRIO = 1, ch0 and ch2 each hold 2 words -> source order 0,0,2,2.
REQ-027 Full/backpressure: ackrx_i = 0, ch0 writes 6 words -> 1 word in the output stage, 4 in the FIFO, acktx_o[0] = 0 with dat_o stable; release ackrx_i -> all 5 words in order.
REQ-028 Reset mid-operation: rst_i = 0 for 1 cycle with 3 words buffered -> validrx_o = 0 immediately, acktx_o = 3'b111, no stale word after release.
REQ-029 Full plus pop in the same cycle: FIFO 0 full, ackrx_i = 1, validtx_i[0] = 1 -> no write that cycle, acktx_o[0] = 1 the next cycle, and occupancy never exceeds 4.
